led_pattern_sequencer: RTL and testbench
========================================

# led_pattern_sequencer

Downstream consumer of the board's slow toggle divider. Treats each transition of the divider's square-wave output as one animation step and drives the on-board RGB LED through a user-selectable pattern. A debounced push button cycles the pattern mode. Output feeds the active-low LED pins directly.

## Interface

Parameters:
- DEBOUNCE_CYCLES, default 240_000: stable-input cycles required to accept a button change (10 ms at 24 MHz); minimum 2.
- LED_ACTIVE_LOW, default 1: 1 gives led_n = ~pattern, 0 gives led_n = pattern.

Ports:
- clock  input  1  system clock (24 MHz on board).
- reset  input  1  asynchronous, active-low.
- step_in  input  1  divider square wave; each edge, rising or falling, is one step.
- mode_n  input  1  raw push button, active-low, asynchronous, bouncy.
- led_n  output  3  RGB drive, bit0 = R, bit1 = G, bit2 = B.
- mode  output  2  current mode, for observability.
- step_pulse  output  1  one-cycle strobe per detected step.

## Operation

- **Synchronisers**
  - step_in passes through 3 flops s1→s2→s3, all resetting to 0. step_pulse = s2 ^ s3.
  - mode_n passes through 2 flops, both resetting to 1 (released).
  - The upstream divider shares this reset and holds 0 at release, so no spurious step occurs.
- **Debouncer**
  - btn_state resets to 1. Counter width is clog2(DEBOUNCE_CYCLES).
  - Each cycle the synced button equals btn_state, the counter clears.
  - Each cycle it differs, the counter increments.
  - When it differs with counter == DEBOUNCE_CYCLES-1, btn_state takes the synced value and the counter clears.
  - A press event is btn_state falling 1→0: a one-cycle internal strobe. Releases generate nothing.
- **Mode FSM** (2-bit, resets to BLINK). Each press advances BLINK(0) → ROTATE(1) → BINARY(2) → HOLD(3) → BLINK.
- **Pattern register** pat[2:0] resets to 000. On a step in each mode:
  - BLINK: pat ← ~pat, toggling between 000 and 111.
  - ROTATE: rotate left, 001→010→100→001.
  - BINARY: pat ← pat+1 mod 8, so 111→000.
  - HOLD: no change; the step is ignored.
- **Pattern on mode entry** (loaded on the press cycle):
  - BLINK loads 000.
  - ROTATE loads 001.
  - BINARY loads 000.
  - HOLD keeps the current pat.
- **Press and step in the same cycle:** the mode change wins, the entry pattern loads, and the step is discarded.
- **Reset values:** mode = 0, pat = 000, led_n = 111 (when LED_ACTIVE_LOW = 1), step_pulse = 0.
- **Reset asserted mid-operation:** all of the above clear immediately. The debounce counter clears and btn_state returns to 1.

## Timing

- **step_in change** seen at clock edge k:
  - s1 updates at edge k.
  - step_pulse is high from edge k+1 to edge k+2, exactly one cycle.
  - pat and led_n update at edge k+2.
- **Debounce:** mode_n held low continuously from edge k:
  - The synced value differs from edge k+2.
  - btn_state falls DEBOUNCE_CYCLES cycles later.
  - mode and pat update on the following edge.
- **Bounce rejection:** any glitch shorter than DEBOUNCE_CYCLES cycles (after sync) produces no event.
- **Step rate:** back-to-back steps are supported at one per cycle, with step_in toggling every cycle.
- **Output path:** led_n is purely combinational from the pat register, with no additional logic.

## Structure

- Shared package/include led_seq_pkg holds:
  - mode encodings MODE_BLINK/ROTATE/BINARY/HOLD;
  - entry patterns PAT_INIT_BLINK = 000, PAT_INIT_ROTATE = 001, PAT_INIT_BINARY = 000.
- Sub-module button_debouncer, containing sync, counter and btn_state.
  - Parameter: DEBOUNCE_CYCLES.
  - Outputs: btn_state and press strobe.
  - Reused for future board buttons.
- Top contains the step synchroniser, mode FSM and pattern datapath.

## Test plan

Simulate with DEBOUNCE_CYCLES = 4.

1. **Reset/idle:** hold reset low, release, no activity for 20 cycles → led_n = 111, mode = 0, step_pulse never high.
2. **BLINK steps:** toggle step_in 0→1 then 1→0, 10 cycles apart → each edge gives one step_pulse 2 cycles later. led_n goes 000, then 111, with pat updating at edge k+2.
3. **Bounce rejection and mode cycling:**
   - Pulse mode_n low for 3 cycles, 5 times, with 2-cycle gaps → mode stays 0.
   - Hold low 10 cycles, release, repeat 4 times → mode goes 1, 2, 3, 0.
   - On ROTATE entry, led_n = 110.
4. **ROTATE/BINARY wrap:**
   - In ROTATE, 3 steps → led_n goes 101, 011, 110.
   - In BINARY, 9 steps → pat goes 001…111, 000, 001.
5. **HOLD and collision:**
   - In BINARY with pat = 101, press → HOLD keeps pat 101, and 5 steps leave it 101.
   - Align the press event with a step_pulse in BINARY → pat = 000 for the new mode, and the step is discarded.
6. **Reset mid-operation:** in BINARY with pat = 110 and the debounce counter at 2, assert reset for 1 cycle → led_n = 111 and mode = 0 immediately. After release, a full press is required to advance the mode.

Source files
------------

// File: rtl/led_seq_pkg.sv
// Shared encodings and pattern rules for the LED pattern sequencer.
// Mode order, entry patterns and per-step pattern transforms live here.
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_BLINK  = 2'd0,
    MODE_ROTATE = 2'd1,
    MODE_BINARY = 2'd2,
    MODE_HOLD   = 2'd3
  } mode_e;

  localparam logic [2:0] PAT_INIT_BLINK  = 3'b000;
  localparam logic [2:0] PAT_INIT_ROTATE = 3'b001;
  localparam logic [2:0] PAT_INIT_BINARY = 3'b000;

  function automatic mode_e next_mode(input mode_e cur);
    mode_e nxt;
    case (cur)
      MODE_BLINK:  nxt = MODE_ROTATE;
      MODE_ROTATE: nxt = MODE_BINARY;
      MODE_BINARY: nxt = MODE_HOLD;
      default:     nxt = MODE_BLINK;
    endcase
    return nxt;
  endfunction

  // HOLD has no entry pattern of its own: it freezes whatever was showing.
  function automatic logic [2:0] entry_pattern(input mode_e new_mode, input logic [2:0] cur_pat);
    logic [2:0] pat;
    case (new_mode)
      MODE_BLINK:  pat = PAT_INIT_BLINK;
      MODE_ROTATE: pat = PAT_INIT_ROTATE;
      MODE_BINARY: pat = PAT_INIT_BINARY;
      default:     pat = cur_pat;
    endcase
    return pat;
  endfunction

  function automatic logic [2:0] step_pattern(input mode_e cur_mode, input logic [2:0] cur_pat);
    logic [2:0] pat;
    case (cur_mode)
      MODE_BLINK:  pat = ~cur_pat;
      MODE_ROTATE: pat = {cur_pat[1:0], cur_pat[2]};
      MODE_BINARY: pat = cur_pat + 3'd1;
      default:     pat = cur_pat;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/led_pattern_sequencer_if.sv
// Board-facing signal bundle of the LED pattern sequencer.
// No backpressure anywhere: step_pulse is a one-cycle strobe that is always consumed.
interface led_pattern_sequencer_if;
  logic       step_in;
  logic       mode_n;
  logic [2:0] led_n;
  logic [1:0] mode;
  logic       step_pulse;
  logic       btn_state;

  modport master (
    output step_in,
    output mode_n,
    input  led_n,
    input  mode,
    input  step_pulse,
    input  btn_state
  );

  modport slave (
    input  step_in,
    input  mode_n,
    output led_n,
    output mode,
    output step_pulse,
    output btn_state
  );
endinterface

// File: rtl/led_pattern_sequencer_debouncer.sv
// Generic push-button debouncer: 2-flop sync, stability counter, accepted state
// and a one-cycle press strobe on each accepted 1->0 transition.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 240_000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_n_i,
  output logic btn_state_o,
  output logic press_o
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             synced;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             btn_q, btn_d;
  logic             btn_prev_q;

  assign synced = sync_q[1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q     <= 2'b11;
      cnt_q      <= '0;
      btn_q      <= 1'b1;
      btn_prev_q <= 1'b1;
    end else begin
      sync_q     <= {sync_q[0], btn_n_i};
      cnt_q      <= cnt_d;
      btn_q      <= btn_d;
      btn_prev_q <= btn_q;
    end
  end

  // Any cycle that agrees with the accepted state restarts the stability count.
  always_comb begin
    cnt_d = cnt_q;
    btn_d = btn_q;
    if (synced == btn_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      btn_d = synced;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign btn_state_o = btn_q;
  assign press_o     = btn_prev_q & ~btn_q;

endmodule

// File: rtl/led_pattern_sequencer.sv
// Steps an RGB LED pattern on every edge of the slow divider output; a
// debounced button cycles BLINK -> ROTATE -> BINARY -> HOLD.
module led_pattern_sequencer
  import led_seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 240_000,
  parameter bit          LED_ACTIVE_LOW  = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset,
  led_pattern_sequencer_if.slave  bus
);

  logic [2:0] step_sync_q;
  logic       step_pulse;
  logic       press;
  logic       btn_state;
  mode_e      mode_q, mode_d;
  logic [2:0] pat_q, pat_d;

  button_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_mode_btn (
    .clock       (clock),
    .reset       (reset),
    .btn_n_i     (bus.mode_n),
    .btn_state_o (btn_state),
    .press_o     (press)
  );

  // Bit 0 is the metastability catcher; edges are taken between bits 1 and 2.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      step_sync_q <= 3'b000;
    end else begin
      step_sync_q <= {step_sync_q[1:0], bus.step_in};
    end
  end

  assign step_pulse = step_sync_q[1] ^ step_sync_q[2];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mode_q <= MODE_BLINK;
      pat_q  <= 3'b000;
    end else begin
      mode_q <= mode_d;
      pat_q  <= pat_d;
    end
  end

  // A press in the same cycle as a step wins; that step is dropped.
  always_comb begin
    mode_d = mode_q;
    pat_d  = pat_q;
    if (press) begin
      mode_d = next_mode(mode_q);
      pat_d  = entry_pattern(mode_d, pat_q);
    end else if (step_pulse) begin
      pat_d  = step_pattern(mode_q, pat_q);
    end
  end

  assign bus.led_n      = LED_ACTIVE_LOW ? ~pat_q : pat_q;
  assign bus.mode       = mode_q;
  assign bus.step_pulse = step_pulse;
  assign bus.btn_state  = btn_state;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Randomised and directed bench for led_pattern_sequencer with a queue-based
// scoreboard fed by a spec-level model and drained by an independent monitor.
module tb_led_pattern_sequencer;

  localparam int DEB = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  led_pattern_sequencer_if bus_if ();

  led_pattern_sequencer #(
    .DEBOUNCE_CYCLES (DEB),
    .LED_ACTIVE_LOW  (1'b1)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  // Each entry is {mode, led_n} expected after one observable event.
  logic [4:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;
  int ref_mode = 0;
  int ref_pat  = 0;
  bit mon_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_step(input int m, input int p);
    case (m)
      0:       return 7 - p;
      1:       return ((p * 2) % 8) + (p / 4);
      2:       return (p + 1) % 8;
      default: return p;
    endcase
  endfunction

  function automatic logic [4:0] model_obs();
    logic [4:0] v;
    v[4:3] = 2'(ref_mode);
    v[2:0] = 3'(7 - ref_pat);
    return v;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_step();
    bus_if.step_in = ~bus_if.step_in;
    ref_pat = model_step(ref_mode, ref_pat);
    exp_q.push_back(model_obs());
  endtask

  task automatic step_gap(input int gap);
    do_step();
    repeat (gap) tick();
  endtask

  task automatic model_press();
    ref_mode = (ref_mode + 1) % 4;
    if (ref_mode == 1)      ref_pat = 1;
    else if (ref_mode != 3) ref_pat = 0;
    exp_q.push_back(model_obs());
  endtask

  task automatic do_press();
    model_press();
    bus_if.mode_n = 1'b0;
    repeat (10) tick();
    bus_if.mode_n = 1'b1;
    repeat (10) tick();
  endtask

  task automatic glitch(input int len);
    bus_if.mode_n = 1'b0;
    repeat (len) tick();
    bus_if.mode_n = 1'b1;
    repeat (2) tick();
  endtask

  // Press strobe lands in the cycle before edge k+7; a step toggled after edge
  // k+4 pulses in that same cycle.
  task automatic press_with_step();
    model_press();
    bus_if.mode_n = 1'b0;
    repeat (4) tick();
    bus_if.step_in = ~bus_if.step_in;
    repeat (6) tick();
    bus_if.mode_n = 1'b1;
    repeat (10) tick();
  endtask

  task automatic step_timed();
    logic [2:0] old_led;
    old_led = 3'(7 - ref_pat);
    do_step();
    @(negedge clock);
    @(negedge clock);
    check("pulse_before", 32'(bus_if.step_pulse), 32'd0);
    @(negedge clock);
    check("pulse_high", 32'(bus_if.step_pulse), 32'd1);
    check("led_before_update", 32'(bus_if.led_n), 32'(old_led));
    @(negedge clock);
    check("pulse_one_cycle", 32'(bus_if.step_pulse), 32'd0);
    check("led_after_update", 32'(bus_if.led_n), 32'(7 - ref_pat));
    repeat (7) tick();
  endtask

  initial begin : monitor
    logic [1:0] last_mode;
    logic [4:0] e;
    bit pend;
    bit trig;
    pend = 1'b0;
    last_mode = 2'd0;
    forever begin
      @(negedge clock);
      if (!mon_en) begin
        pend = 1'b0;
        last_mode = bus_if.mode;
      end else begin
        trig = pend || (bus_if.mode !== last_mode);
        if (trig) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_event: mode=%0d led_n=%b with nothing expected at %0t",
                     bus_if.mode, bus_if.led_n, $time);
          end else begin
            e = exp_q.pop_front();
            check("observed_state", 32'({bus_if.mode, bus_if.led_n}), 32'(e));
          end
        end
        pend = bus_if.step_pulse;
        last_mode = bus_if.mode;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int highs;
    int r;
    int drain;
    bus_if.step_in = 1'b0;
    bus_if.mode_n  = 1'b1;

    // Reset and idle
    repeat (3) tick();
    reset = 1'b1;
    @(negedge clock);
    check("reset_led_n", 32'(bus_if.led_n), 32'h7);
    check("reset_mode", 32'(bus_if.mode), 32'd0);
    check("reset_step_pulse", 32'(bus_if.step_pulse), 32'd0);
    check("reset_btn_state", 32'(bus_if.btn_state), 32'd1);
    mon_en = 1'b1;
    highs = 0;
    repeat (20) begin
      @(negedge clock);
      if (bus_if.step_pulse) highs++;
    end
    check("idle_no_pulse", 32'(highs), 32'd0);
    tick();

    // BLINK steps, both edge directions
    step_timed();
    step_timed();

    // Bounce rejection, then full mode cycle
    repeat (5) glitch(3);
    repeat (6) tick();
    check("glitch_mode_stays", 32'(bus_if.mode), 32'd0);
    do_press();
    check("rotate_entry_led", 32'(bus_if.led_n), 32'b110);
    do_press();
    do_press();
    do_press();

    // ROTATE and BINARY wrap
    do_press();
    repeat (3) step_gap(4);
    do_press();
    repeat (9) step_gap(3);

    // HOLD freezes 101, then collisions
    repeat (4) step_gap(3);
    do_press();
    check("hold_entry_led", 32'(bus_if.led_n), 32'b010);
    repeat (5) step_gap(3);
    check("hold_after_steps", 32'(bus_if.led_n), 32'b010);
    press_with_step();
    check("collision_to_blink", 32'({bus_if.mode, bus_if.led_n}), 32'b00111);
    do_press();
    do_press();
    repeat (3) step_gap(3);
    press_with_step();
    check("collision_to_hold", 32'({bus_if.mode, bus_if.led_n}), 32'b11100);
    do_press();

    // Reset in BINARY at pat 110 with a press in progress
    do_press();
    do_press();
    repeat (6) step_gap(3);
    check("pre_reset_led", 32'(bus_if.led_n), 32'b001);
    repeat (4) tick();
    bus_if.mode_n = 1'b0;
    repeat (4) tick();
    mon_en = 1'b0;
    check("queue_drained_before_reset", 32'(exp_q.size()), 32'd0);
    reset = 1'b0;
    bus_if.mode_n = 1'b1;
    #1;
    check("midreset_led_n", 32'(bus_if.led_n), 32'h7);
    check("midreset_mode", 32'(bus_if.mode), 32'd0);
    check("midreset_pulse", 32'(bus_if.step_pulse), 32'd0);
    tick();
    reset = 1'b1;
    ref_mode = 0;
    ref_pat  = 0;
    repeat (2) tick();
    mon_en = 1'b1;
    glitch(3);
    repeat (4) tick();
    check("post_reset_glitch_mode", 32'(bus_if.mode), 32'd0);
    do_press();
    check("post_reset_press", 32'({bus_if.mode, bus_if.led_n}), 32'b01110);

    // Randomised mix of steps, bursts, glitches and presses
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 11);
      if (r <= 4) begin
        step_gap($urandom_range(1, 5));
      end else if (r <= 6) begin
        repeat ($urandom_range(2, 6)) step_gap(1);
        repeat (3) tick();
      end else if (r <= 8) begin
        glitch($urandom_range(1, DEB - 1));
      end else begin
        do_press();
      end
    end

    drain = 0;
    while (exp_q.size() > 0 && drain < 50) begin
      tick();
      drain++;
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("final_state", 32'({bus_if.mode, bus_if.led_n}), 32'(model_obs()));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
